// File: rtl/restador_serie_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the counter-width helper.
package restador_serie_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter holds 0..WIDTH, hence one bit beyond ceil(log2(WIDTH)).
    function automatic int unsigned cnt_bits(input int unsigned w);
        return int'($clog2(w)) + 1;
    endfunction

endpackage

// File: rtl/restador_serie_celda_resta.sv
// One-bit full subtractor cell: d = x - y - bin, bout is the borrow-out.
module celda_resta (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_xor;

    assign w_xor = x ^ y;
    assign d     = w_xor ^ bin;
    assign bout  = (~x & y) | (~w_xor & bin);

endmodule

// File: rtl/restador_serie.sv
// Bit-serial LSB-first subtractor: diff = a - b mod 2^WIDTH plus final borrow.
// Define RESTADOR_SERIE_OVF_EN to add the signed-overflow output ovf.
module restador_serie
    import restador_serie_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef RESTADOR_SERIE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = cnt_bits(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_bin;
    logic [CNT_W-1:0] r_cnt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_d;
    logic             w_bout;

    celda_resta u_celda (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    // Next-state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Status flags registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_SHIFT);
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    // Operand shift registers, partial result, running borrow and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_bin <= 1'b0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_a   <= a;
            r_b   <= b;
            r_bin <= 1'b0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_bin <= w_bout;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Published result changes only on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_last) begin
            r_diff   <= {w_d, r_res[WIDTH-1:1]};
            r_borrow <= w_bout;
        end
    end

`ifdef RESTADOR_SERIE_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Operand sign bits are lost to shifting, so capture them at load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_load) begin
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end
            if (w_last) begin
                r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            end
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_restador_serie.sv
// Randomized and directed bench for restador_serie (WIDTH=8) against a
// latency/arithmetic reference model.
module tb_restador_serie;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef RESTADOR_SERIE_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    restador_serie #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef RESTADOR_SERIE_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the edge count since acceptance and computes the
    // arithmetic result directly.
    logic         m_valid = 1'b0;
    logic         m_active = 1'b0;
    int           m_k = 0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_borrow = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] p_diff = '0;
    logic         p_borrow = 1'b0;
    logic         p_ovf = 1'b0;
    int           sd;

    always @(posedge clk) begin
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_diff   = '0;
            m_borrow = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_k == int'(W)) begin
                    m_busy   = 1'b0;
                    m_done   = 1'b1;
                    m_diff   = p_diff;
                    m_borrow = p_borrow;
                    m_ovf    = p_ovf;
                end else if (m_k == int'(W) + 1) begin
                    m_active = 1'b0;
                end
            end else if (start) begin
                m_active = 1'b1;
                m_k      = 0;
                m_busy   = 1'b1;
                p_diff   = W'(a - b);
                p_borrow = (a < b);
                sd       = int'($signed(a)) - int'($signed(b));
                p_ovf    = (sd > 127) || (sd < -128);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("diff", 32'(diff), 32'(m_diff));
            chk("borrow", 32'(borrow), 32'(m_borrow));
`ifdef RESTADOR_SERIE_OVF_EN
            chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    // Called at a negedge; start accepted on the next edge, returns at a negedge in IDLE.
    task automatic do_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
        int n;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(W + 1));
        chk({name, "_diff"}, 32'(diff), 32'(ed));
        chk({name, "_borrow"}, 32'(borrow), 32'(eb));
`ifdef RESTADOR_SERIE_OVF_EN
        chk({name, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unreachable");
`endif
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        logic [W-1:0] corner [4];
        corner[0] = 8'h00;
        corner[1] = 8'hFF;
        corner[2] = 8'h80;
        corner[3] = 8'h7F;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        rst = 1'b0;

        // First start lands on the first edge with rst low.
        do_op("op_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        do_op("op_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        do_op("op_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        do_op("op_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Start while shifting must be ignored.
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("ignore_start_ndone", 32'(ndone), 32'd1);
        chk("ignore_start_diff", 32'(diff), 32'h0F);
        chk("ignore_start_borrow", 32'(borrow), 32'd0);

        // Reset mid-operation aborts without a done pulse.
        a = 8'h20; b = 8'h03; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_ndone", 32'(ndone), 32'd0);
        do_op("op_0a_0b", 8'h0A, 8'h0B, 8'hFF, 1'b1, 1'b0);

        // Randomized traffic: starts at any time, occasional resets, corner operands.
        repeat (800) begin
            rst   = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
